// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / branch-LUT slice.
package pc_pkg;

  localparam int unsigned D  = 9;
  localparam int unsigned LW = 5;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  // Branch label indices into the target LUT
  localparam logic [LW-1:0] LBL_LOOP   = 5'd0;
  localparam logic [LW-1:0] LBL_SKIP   = 5'd1;
  localparam logic [LW-1:0] LBL_ESCAPE = 5'd19;

endpackage

// File: rtl/pc_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module pc_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC register and next-PC selection (sequential, branch via external LUT,
// stall, halt) with start/done sequencing and a retired-instruction count.
module pc_branch_ctrl #(
  parameter int unsigned D  = pc_pkg::D,
  parameter int unsigned LW = pc_pkg::LW,
  parameter int unsigned CW = pc_pkg::CW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic [LW-1:0] BranchIdx,
  input  logic          Halt,
  input  logic [D-1:0]  Target,
  output logic [LW-1:0] LutAddr,
  output logic [D-1:0]  Prog_ctr,
  output logic          Running,
  output logic          Done,
  output logic [CW-1:0] InstCount
);

  import pc_pkg::*;

  pc_state_e      state_q;
  pc_state_e      state_d;
  logic [D-1:0]   pc_q;
  logic [D-1:0]   pc_d;
  logic           cnt_clr;
  logic           cnt_en;

  assign LutAddr = BranchIdx;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (Start) begin
          pc_d    = '0;
          cnt_clr = 1'b1;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (Halt) begin
          // The halting instruction itself retires; PC stays on it
          state_d = ST_HALTED;
          cnt_en  = 1'b1;
        end else if (BranchEn) begin
          pc_d   = Target;
          cnt_en = 1'b1;
        end else begin
          pc_d   = pc_q + D'(1);
          cnt_en = 1'b1;
        end
      end
      ST_HALTED: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  pc_sat_counter #(
    .W(CW)
  ) u_inst_count (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(InstCount)
  );

  assign Prog_ctr = pc_q;
  assign Running  = (state_q == ST_RUN);
  assign Done     = (state_q == ST_HALTED);

endmodule
